// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state encoding, word type and index-width helper for the responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef logic [31:0] word_t;
  function automatic int idx_bits(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: processor-side request/response handshake bundle.
interface mem_responder_if;
  import mem_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_we;
  word_t req_addr;
  word_t req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  word_t rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/resp_ram.sv
// resp_ram: word storage with synchronous write and combinational read; never cleared.
module resp_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = idx_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);
  word_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with WAIT wait states and error checking.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int AW = idx_bits(DEPTH);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d;
  word_t addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic accept, enter_resp, eff_we, eff_err, ram_we;
  word_t eff_addr, eff_wdata, ram_rdata;
  // With WAIT=0 the response is formed on the acceptance edge itself, so act on the live request there
  assign accept     = state_q == IDLE && bus.req_valid;
  assign eff_we     = accept ? bus.req_we    : we_q;
  assign eff_addr   = accept ? bus.req_addr  : addr_q;
  assign eff_wdata  = accept ? bus.req_wdata : wdata_q;
  assign eff_err    = eff_addr[1:0] != 2'd0 || eff_addr[31:2] >= 30'(DEPTH);
  assign enter_resp = (accept && WAIT == 0) || (state_q == BUSY && cnt_q == 4'd0);
  assign ram_we     = enter_resp && eff_we && !eff_err && reset;
  resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (eff_addr[AW+1:2]),
    .wdata_i (eff_wdata),
    .raddr_i (eff_addr[AW+1:2]),
    .rdata_o (ram_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = accept ? bus.req_we    : we_q;
    addr_d  = accept ? bus.req_addr  : addr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept && WAIT != 0) begin
      state_d = BUSY;
      cnt_d   = 4'(WAIT - 1);
    end
    if (state_q == BUSY) cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    if (enter_resp) begin
      state_d = RESP;
      rdata_d = (eff_we || eff_err) ? '0 : ram_rdata;
      err_d   = eff_err;
    end
    if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives a WAIT=0 and a WAIT=2 responder against a word-array reference model.
module tb_mem_responder;
  import mem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_responder_if b0 ();
  mem_responder_if b2 ();
  mem_responder #(.DEPTH(64), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  mem_responder #(.DEPTH(64), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  logic rv [2], rwe [2], rr [2], rdy [2], vld [2], er [2];
  word_t ra [2], rwd [2], rd [2];
  assign b0.req_valid = rv[0];
  assign b0.req_we    = rwe[0];
  assign b0.req_addr  = ra[0];
  assign b0.req_wdata = rwd[0];
  assign b0.rsp_ready = rr[0];
  assign rdy[0] = b0.req_ready;
  assign vld[0] = b0.rsp_valid;
  assign rd[0]  = b0.rsp_rdata;
  assign er[0]  = b0.rsp_err;
  assign b2.req_valid = rv[1];
  assign b2.req_we    = rwe[1];
  assign b2.req_addr  = ra[1];
  assign b2.req_wdata = rwd[1];
  assign b2.rsp_ready = rr[1];
  assign rdy[1] = b2.req_ready;
  assign vld[1] = b2.rsp_valid;
  assign rd[1]  = b2.rsp_rdata;
  assign er[1]  = b2.rsp_err;
  word_t model [2][64];
  int wait_of [2] = '{0, 2};
  int nchk = 0;
  int nfail = 0;
  task automatic chk(input string tag, input word_t obs, input word_t exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One complete transaction; hold = cycles rsp_ready stays low in RESP (0 = tied high throughout)
  task automatic txn(input int s, input bit we, input word_t addr, input word_t wd, input int hold);
    int n;
    bit exp_err;
    word_t exp_rd;
    n = 0;
    while (!rdy[s] && n < 40) begin
      step();
      n++;
    end
    chk("ready_before_req", 32'(rdy[s]), 1);
    exp_err = addr[1:0] != 2'd0 || addr[31:2] >= 30'd64;
    exp_rd  = (we || exp_err) ? 32'd0 : model[s][addr[7:2]];
    rv[s] = 1'b1; rwe[s] = we; ra[s] = addr; rwd[s] = wd; rr[s] = (hold == 0);
    step();
    rwe[s] = 1'b1; ra[s] = 32'($urandom_range(0, 63) * 4); rwd[s] = $urandom;
    n = 0;
    while (!vld[s] && n < 20) begin
      chk("ready_low_busy", 32'(rdy[s]), 0);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(wait_of[s]));
    chk("rsp_rdata", rd[s], exp_rd);
    chk("rsp_err", 32'(er[s]), 32'(exp_err));
    chk("ready_low_resp", 32'(rdy[s]), 0);
    for (int i = 0; i < hold; i++) begin
      ra[s] = 32'($urandom_range(0, 63) * 4);
      step();
      chk("hold_valid", 32'(vld[s]), 1);
      chk("hold_rdata", rd[s], exp_rd);
      chk("hold_err", 32'(er[s]), 32'(exp_err));
      chk("hold_no_accept", 32'(rdy[s]), 0);
    end
    rr[s] = 1'b1; rv[s] = 1'b0;
    step();
    chk("valid_cleared", 32'(vld[s]), 0);
    chk("rdata_cleared", rd[s], 0);
    chk("err_cleared", 32'(er[s]), 0);
    chk("ready_after", 32'(rdy[s]), 1);
    rr[s] = 1'b0;
    if (we && !exp_err) model[s][addr[7:2]] = wd;
  endtask
  task automatic chk_reset_outputs();
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(rdy[s]), 1);
      chk("rst_valid", 32'(vld[s]), 0);
      chk("rst_rdata", rd[s], 0);
      chk("rst_err", 32'(er[s]), 0);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int r, idx;
    word_t prior;
    for (int s = 0; s < 2; s++) begin
      rv[s] = 0; rwe[s] = 0; rr[s] = 0; ra[s] = 0; rwd[s] = 0;
    end
    #1 reset = 1'b0;
    #1 chk_reset_outputs();
    #10 reset = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++) txn(s, 1'b1, 32'(w * 4), $urandom, 0);
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1, 1'b0, 32'h10, 32'h0, 0);
    chk("load_deadbeef", model[1][4], 32'hDEADBEEF);
    txn(1, 1'b0, 32'h12, 32'h0, 1);
    txn(1, 1'b0, 32'h100, 32'h0, 1);
    txn(1, 1'b1, 32'h100, 32'hBAD0BAD0, 0);
    txn(1, 1'b0, 32'h14, 32'h0, 5);
    txn(0, 1'b1, 32'h4, 32'h5, 0);
    txn(0, 1'b0, 32'h4, 32'h0, 0);
    chk("wait0_load5", model[0][1], 32'h5);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      idx = $urandom_range(0, 63);
      if (r < 4) txn(k % 2, 1'b1, 32'(idx * 4), $urandom, $urandom_range(0, 2));
      else if (r < 7) txn(k % 2, 1'b0, 32'(idx * 4), 0, $urandom_range(0, 2));
      else if (r < 8) txn(k % 2, r[0], 32'(idx * 4 + $urandom_range(1, 3)), $urandom, $urandom_range(0, 2));
      else txn(k % 2, r[0], $urandom | 32'h100, $urandom, $urandom_range(0, 2));
    end
    prior = model[1][2];
    rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 32'h8; rwd[1] = 32'h12345678;
    step();
    rv[1] = 1'b0;
    step();
    chk("busy_before_reset", 32'(rdy[1]), 0);
    reset = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk);
    #3 reset = 1'b1;
    txn(1, 1'b0, 32'h8, 32'h0, 0);
    chk("reset_kept_prior", model[1][2], prior);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 64; w++) txn(s, 1'b0, 32'(w * 4), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in storage.
REQ-002 Parameter WAIT, default 2, legal range 0..15: wait-state cycles between request acceptance and response.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous, active-low (asserted at 0).
REQ-006 Port req_valid, input, 1: processor presents a request.
REQ-007 Port req_ready, output, 1: responder can accept a request.
REQ-008 Port req_we, input, 1: 1 = store, 0 = load.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, 32: store data.
REQ-011 Port rsp_valid, output, 1: response available.
REQ-012 Port rsp_ready, input, 1: processor consumes the response.
REQ-013 Port rsp_rdata, output, 32: load data; 0 for stores and errors.
REQ-014 Port rsp_err, output, 1: request was misaligned (req_addr[1:0] != 0) or out of range (req_addr[31:2] >= DEPTH).

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 On acceptance, the block SHALL latch req_we, req_addr and req_wdata; later changes on req_* SHALL have no effect until the next acceptance.
REQ-018 On acceptance with WAIT > 0: go to BUSY and load the 4-bit wait counter with WAIT-1.
REQ-019 On acceptance with WAIT = 0: go directly to RESP.
REQ-020 In BUSY, the counter SHALL decrement each cycle; on the edge where it equals 0, go to RESP.
REQ-021 rsp_valid SHALL first be 1 in the cycle after edge E0+WAIT, where E0 is the acceptance edge (latency WAIT+1 cycles).
REQ-022 On the edge entering RESP, a legal store SHALL write the latched data to word req_addr[31:2].
REQ-023 On the edge entering RESP, a legal load SHALL register the word into rsp_rdata.
REQ-024 For an erroring request: no storage write, rsp_rdata = 0, rsp_err = 1.
REQ-025 For a non-erroring request, rsp_err SHALL be 0.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1.
REQ-027 On the edge where rsp_valid and rsp_ready are both 1: return to IDLE, clear rsp_valid, rsp_err and rsp_rdata.
REQ-028 req_ready SHALL NOT be asserted in the cycle of the RESP-to-IDLE edge; maximum throughput is one request per WAIT+2 cycles.
REQ-029 A load to an address stored by the immediately preceding request SHALL return the new data.
REQ-030 req_valid SHALL be ignored outside IDLE.
REQ-031 rsp_ready SHALL be ignored outside RESP.
REQ-032 Storage contents SHALL be undefined after power-up; no initialisation file is read.

Reset
REQ-033 Reset assertion SHALL immediately force: state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, latched request fields 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no storage write, unless the write edge already occurred.
REQ-035 Storage contents SHALL NOT be cleared by reset.
REQ-036 Deassertion SHALL take effect without requiring any particular clock phase; the first acceptance is possible on the first rising edge after deassertion.

Structure
REQ-037 Shared package mem_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and a 32-bit word typedef.
REQ-038 Storage SHALL be a sub-module resp_ram: synchronous write, combinational read, parameterised by DEPTH, instanced once.
REQ-039 The FSM, counter and response registers SHALL reside in mem_responder.

Verification
REQ-040 WAIT=2: store 0xDEADBEEF to 0x00000010 -> req_ready low 3 cycles; rsp_valid high in cycle 3 after acceptance; rsp_err 0; rsp_rdata 0.
REQ-041 WAIT=2: load 0x00000010 after the REQ-040 store -> rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-042 Load 0x00000012 (misaligned) and load 0x00000100 (word 64, DEPTH=64) -> rsp_err 1 and rsp_rdata 0 for each; no storage change.
REQ-043 rsp_ready held 0 for 5 cycles in RESP while req_valid stays 1 with changing req_addr -> response stable; no new acceptance; exactly one request accepted.
REQ-044 WAIT=0: back-to-back store 0x5 to 0x4, then load 0x4, with rsp_ready tied 1 -> each rsp_valid one cycle after acceptance; load returns 0x00000005.
REQ-045 Reset pulsed low in BUSY of a store of 0x12345678 to 0x8 -> outputs at reset values immediately; subsequent load of 0x8 returns the prior contents.
